// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: word RAM with byte/half/word access,
// a small MMIO window (LEDs, switches, cycle counter), and a stall back to the pipeline.
module dmem_responder #(
    parameter int          DEPTH     = 16384,
    parameter int          READ_LAT  = 1,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_FC00,
    parameter int          SW_W      = 16,
    parameter int          LED_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    input  logic [2:0]       req_funct3,
    output logic             resp_valid,
    output logic [31:0]      resp_rdata,
    output logic             resp_err,
    output logic             stall,
    input  logic [SW_W-1:0]  sw_in,
    output logic [LED_W-1:0] led_out
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    state_t r_state, w_next;

    logic [31:0]      r_mem [DEPTH];
    logic [31:0]      r_ram_q, r_rdata, r_cyc;
    logic [AW-1:0]    r_word;
    logic [1:0]       r_off;
    logic [2:0]       r_f3;
    logic             r_err, r_from_ram;
    logic [CW-1:0]    r_lat;
    logic [LED_W-1:0] r_led;
    logic [SW_W-1:0]  r_sw1, r_sw2;

    logic          w_accept, w_misal, w_illegal, w_ram_hit, w_mmio_hit, w_err;
    logic          w_ram_ld, w_ram_st, w_mmio_st, w_lat_done;
    logic [1:0]    w_size;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata, w_mmio_rd;
    logic [AW-1:0] w_word;

    // Decode, in priority order: misalignment, illegal funct3, RAM, MMIO
    assign w_accept   = req_valid & req_ready;
    assign w_size     = req_funct3[1:0];
    assign w_word     = req_addr[AW+1:2];
    assign w_misal    = (w_size == 2'b01 && req_addr[0]) ||
                        (w_size == 2'b10 && req_addr[1:0] != 2'b00);
    assign w_illegal  = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                        (req_write && req_funct3[2]);
    assign w_ram_hit  = {2'b00, req_addr[31:2]} < 32'(DEPTH);
    assign w_mmio_hit = (req_addr[31:4] == MMIO_BASE[31:4]) && (req_funct3 == 3'b010) &&
                        (req_addr[3:2] != 2'b11);
    assign w_err      = w_misal || w_illegal || !(w_ram_hit || w_mmio_hit);
    assign w_ram_ld   = w_accept && !w_err && w_ram_hit && !req_write;
    assign w_ram_st   = w_accept && !w_err && w_ram_hit && req_write;
    assign w_mmio_st  = w_accept && !w_err && !w_ram_hit && req_write;
    assign w_lat_done = (r_lat == CW'(READ_LAT - 1));

    assign w_be    = (w_size == 2'b00) ? (4'b0001 << req_addr[1:0]) :
                     (w_size == 2'b01) ? (4'b0011 << req_addr[1:0]) : 4'b1111;
    assign w_wdata = (w_size == 2'b00) ? {4{req_wdata[7:0]}} :
                     (w_size == 2'b01) ? {2{req_wdata[15:0]}} : req_wdata;

    always_comb begin
        w_mmio_rd = 32'h0;
        case (req_addr[3:2])
            2'b00:   w_mmio_rd = 32'(r_led);
            2'b01:   w_mmio_rd = 32'(r_sw2);
            2'b10:   w_mmio_rd = r_cyc;
            default: w_mmio_rd = 32'h0;
        endcase
    end

    function automatic logic [31:0] f_extract(input logic [31:0] word, input logic [1:0] off,
                                              input logic [2:0] f3);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b100:  return {24'h0, sh[7:0]};
            3'b101:  return {16'h0, sh[15:0]};
            default: return word;
        endcase
    endfunction

    // RAM is never cleared; stores commit at the accept edge so a later load sees them
    always_ff @(posedge clk) begin
        if (w_ram_st && !rst)
            for (int b = 0; b < 4; b++)
                if (w_be[b]) r_mem[w_word][8*b +: 8] <= w_wdata[8*b +: 8];
        if (r_state == S_WAIT && w_lat_done)
            r_ram_q <= r_mem[r_word];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cyc      <= 32'h0;
            r_sw1      <= '0;
            r_sw2      <= '0;
            r_led      <= '0;
            r_lat      <= '0;
            r_rdata    <= 32'h0;
            r_err      <= 1'b0;
            r_from_ram <= 1'b0;
            r_word     <= '0;
            r_off      <= 2'b00;
            r_f3       <= 3'b000;
        end else begin
            r_state <= w_next;
            r_cyc   <= r_cyc + 32'd1;
            r_sw1   <= sw_in;
            r_sw2   <= r_sw1;
            if (w_accept) begin
                r_word     <= w_word;
                r_off      <= req_addr[1:0];
                r_f3       <= req_funct3;
                r_err      <= w_err;
                r_from_ram <= w_ram_ld;
                r_lat      <= '0;
                r_rdata    <= (w_err || req_write || w_ram_hit) ? 32'h0 : w_mmio_rd;
                if (w_mmio_st && req_addr[3:2] == 2'b00)
                    r_led <= req_wdata[LED_W-1:0];
            end else if (r_state == S_WAIT) begin
                r_lat <= r_lat + CW'(1);
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        stall      = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                stall     = req_valid;
                if (w_accept) w_next = w_ram_ld ? S_WAIT : S_RESP;
            end
            S_WAIT: begin
                stall = 1'b1;
                if (w_lat_done) w_next = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                w_next     = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign resp_err   = resp_valid & r_err;
    assign resp_rdata = !resp_valid ? 32'h0 :
                        r_from_ram  ? f_extract(r_ram_q, r_off, r_f3) : r_rdata;
    assign led_out    = r_led;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed + randomized bench for dmem_responder, checked against a byte-level memory model.
module tb_dmem_responder;
    localparam int          DEPTH    = 16384;
    localparam int          READ_LAT = 1;
    localparam int          SW_W     = 16;
    localparam int          LED_W    = 16;
    localparam logic [31:0] MB       = 32'hFFFF_FC00;

    logic             clk, rst, req_valid, req_ready, req_write, resp_valid, resp_err, stall;
    logic [31:0]      req_addr, req_wdata, resp_rdata;
    logic [2:0]       req_funct3;
    logic [SW_W-1:0]  sw_in;
    logic [LED_W-1:0] led_out;

    dmem_responder #(.DEPTH(DEPTH), .READ_LAT(READ_LAT), .MMIO_BASE(MB),
                     .SW_W(SW_W), .LED_W(LED_W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_funct3(req_funct3), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .stall(stall), .sw_in(sw_in), .led_out(led_out));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index since reset release: the value the MMIO counter must show
    int tb_cyc;
    always @(posedge clk) if (rst) tb_cyc <= 0; else tb_cyc <= tb_cyc + 1;

    logic [7:0]       m_bytes [int unsigned];
    logic [LED_W-1:0] m_led;
    int n_assert, n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference behaviour straight from the access rules: byte-addressed memory
    task automatic model(input bit w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] f3, input int cyc,
                         output bit e, output logic [31:0] rd, output int lat);
        int size;
        logic [31:0] val, off;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        e = 0; rd = 0; lat = 1; val = 0;
        if (a % size != 0) e = 1;
        else if (f3 == 3 || f3 == 6 || f3 == 7 || (w && f3 >= 4)) e = 1;
        else if (a < 4 * DEPTH) begin
            if (w) begin
                for (int i = 0; i < size; i++) m_bytes[int'(a) + i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < size; i++) val[8*i +: 8] = m_bytes[int'(a) + i];
                if (f3 == 3'd0)      rd = 32'($signed(val[7:0]));
                else if (f3 == 3'd1) rd = 32'($signed(val[15:0]));
                else                 rd = val;
                lat = 1 + READ_LAT;
            end
        end else if (a >= MB && a < MB + 12 && f3 == 3'd2) begin
            off = a - MB;
            if (w) begin
                if (off == 0) m_led = wd[LED_W-1:0];
            end else begin
                rd = (off == 0) ? 32'(m_led) : (off == 4) ? 32'(sw_in) : 32'(cyc);
            end
        end else e = 1;
    endtask

    task automatic xact(input string tag, input bit w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] f3, output logic [31:0] got);
        bit e_err; logic [31:0] e_rd; int e_lat, lat;
        @(negedge clk);
        model(w, a, wd, f3, tb_cyc, e_err, e_rd, e_lat);
        req_valid = 1; req_write = w; req_addr = a; req_wdata = wd; req_funct3 = f3;
        #1;
        check({tag, ":stall_req"}, 32'(stall), 32'd1);
        check({tag, ":ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 0; req_wdata = $urandom; req_addr = $urandom;
        lat = 0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge clk);
            if (resp_valid) lat = k;
            else check({tag, ":stall_wait"}, 32'(stall), 32'd1);
        end
        got = 32'hx;
        if (lat == 0) begin
            n_assert++; n_fail++;
            $error("FAIL %s:timeout observed no resp_valid expected within 8 cycles", tag);
        end else begin
            got = resp_rdata;
            check({tag, ":lat"}, 32'(lat), 32'(e_lat));
            check({tag, ":err"}, 32'(resp_err), 32'(e_err));
            check({tag, ":rdata"}, resp_rdata, e_rd);
            check({tag, ":stall_resp"}, 32'(stall), 32'd0);
            check({tag, ":led"}, 32'(led_out), 32'(m_led));
        end
    endtask

    initial begin
        logic [31:0] g, g1, g2;
        int a1, a2;
        logic [2:0] ld_f3 [5];
        ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        n_assert = 0; n_fail = 0; m_led = 0;
        rst = 1; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_funct3 = 0;
        sw_in = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 0;
        #1;
        check("rst:ready", 32'(req_ready), 32'd1);
        check("rst:resp_valid", 32'(resp_valid), 32'd0);
        check("rst:rdata", resp_rdata, 32'd0);
        check("rst:err", 32'(resp_err), 32'd0);
        check("rst:led", 32'(led_out), 32'd0);
        check("rst:stall", 32'(stall), 32'd0);

        for (int i = 0; i < 16; i++) xact("init", 1, 32'(4 * i), $urandom, 3'd2, g);

        xact("t1_sw", 1, 32'h10, 32'hDEADBEEF, 3'd2, g);
        xact("t1_lw", 0, 32'h10, 0, 3'd2, g);
        check("t1_val", g, 32'hDEADBEEF);
        xact("t2_lb", 0, 32'h13, 0, 3'd0, g);  check("t2_lb_val", g, 32'hFFFFFFDE);
        xact("t2_lbu", 0, 32'h13, 0, 3'd4, g); check("t2_lbu_val", g, 32'h000000DE);
        xact("t2_lh", 0, 32'h12, 0, 3'd1, g);  check("t2_lh_val", g, 32'hFFFFDEAD);
        xact("t2_lhu", 0, 32'h10, 0, 3'd5, g); check("t2_lhu_val", g, 32'h0000BEEF);
        xact("t3_sb", 1, 32'h11, 32'h000000AA, 3'd0, g);
        xact("t3_lw", 0, 32'h10, 0, 3'd2, g);  check("t3_val", g, 32'hDEADAAEF);

        xact("t4_led", 1, MB, 32'h1234, 3'd2, g);
        check("t4_led_val", 32'(led_out), 32'h1234);
        xact("t4_led_rd", 0, MB, 0, 3'd2, g);
        sw_in = 16'h00F0;
        repeat (3) @(negedge clk);
        xact("t4_sw", 0, MB + 4, 0, 3'd2, g);  check("t4_sw_val", g, 32'h000000F0);
        xact("t4_swst", 1, MB + 4, 32'hFFFF, 3'd2, g);
        a1 = tb_cyc + 1;
        xact("t4_cyc1", 0, MB + 8, 0, 3'd2, g1);
        repeat (3) @(negedge clk);
        a2 = tb_cyc + 1;
        xact("t4_cyc2", 0, MB + 8, 0, 3'd2, g2);
        check("t4_cyc_diff", g2 - g1, 32'(a2 - a1));

        xact("t5_lw2", 0, 32'h2, 0, 3'd2, g);
        xact("t5_sh1", 1, 32'h1, 32'h5555, 3'd1, g);
        xact("t5_lw0", 0, 32'h0, 0, 3'd2, g);
        xact("t5_oob", 0, 32'(4 * DEPTH), 0, 3'd2, g);
        xact("t5_mmioC", 0, MB + 12, 0, 3'd2, g);
        xact("t5_mmio_lb", 0, MB, 0, 3'd0, g);
        xact("t5_f3_3", 0, 32'h8, 0, 3'd3, g);
        xact("t5_sbu", 1, 32'h8, 32'h77, 3'd4, g);
        xact("t5_led_kept", 0, MB, 0, 3'd2, g);

        // Reset while a RAM load sits in WAIT: the response must be dropped
        @(negedge clk);
        req_valid = 1; req_write = 0; req_addr = 32'h10; req_funct3 = 3'd2;
        @(posedge clk);
        #1 req_valid = 0; rst = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t6_no_resp", 32'(resp_valid), 32'd0);
        end
        rst = 0; m_led = 0;
        #1;
        check("t6_ready", 32'(req_ready), 32'd1);
        check("t6_led", 32'(led_out), 32'd0);
        @(negedge clk);
        check("t6_no_resp_after", 32'(resp_valid), 32'd0);
        xact("t6_lw", 0, 32'h10, 0, 3'd2, g);  check("t6_val", g, 32'hDEADAAEF);

        for (int i = 0; i < 80; i++) begin
            logic [31:0] ra;
            ra = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 9) == 0)
                xact("rnd_any", $urandom_range(0, 1), ra, $urandom, 3'($urandom_range(0, 7)), g);
            else if ($urandom_range(0, 1) == 1)
                xact("rnd_st", 1, ra, $urandom, 3'($urandom_range(0, 2)), g);
            else
                xact("rnd_ld", 0, ra, 0, ld_f3[$urandom_range(0, 4)], g);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder side of the CPU's data-memory interface: accepts one load/store request at a time from the MEM stage and performs byte/half/word access to an internal word RAM or a small MMIO window.
- Returns load data with RISC-V sign or zero extension.
- Drives a stall back to the pipeline while a request is outstanding.
- Sits between the MEM stage and the board's LEDs and switches.

Parameters:
DEPTH, 16384, number of 32-bit RAM words; RAM region is byte addresses 0 to 4*DEPTH-1
READ_LAT, 1, RAM read latency in cycles (>=1)
MMIO_BASE, 32'hFFFF_FC00, base of 16-byte MMIO window; bits [3:0] are zero
SW_W, 16, switch input width
LED_W, 16, LED register width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid  in  1  request present
req_ready  out  1  responder can accept
req_write  in  1  1 = store, 0 = load
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
req_funct3  in  3  load: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; store: 000 sb, 001 sh, 010 sw
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  valid only with resp_valid
stall  out  1  hold-pipeline indication
sw_in  in  SW_W  asynchronous board switches
led_out  out  LED_W  LED register

Behaviour:
- Reset: state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; led_out=0; cycle counter=0; switch synchronizer=0. RAM contents are not cleared.
- FSM states:
  - IDLE: req_ready=1.
  - WAIT: counts READ_LAT cycles.
  - RESP: resp_valid=1 for one cycle, then IDLE.
  - req_ready=0 in WAIT and RESP.
- Accept: a request is accepted in cycle N when req_valid&req_ready; address, funct3, write and wdata are latched at that edge.
- Stall: stall = (req_valid & state==IDLE) | state==WAIT. It is low in the RESP cycle so the pipeline advances with the data.
- Decode, in priority order:
  - Misaligned: half access with addr[0]=1, or word access with addr[1:0]!=0 -> error.
  - Illegal funct3 (011, 110, 111, or 100/101 on a store) -> error.
  - RAM hit: addr[31:2] < DEPTH.
  - MMIO hit: addr[31:4]==MMIO_BASE[31:4] and funct3==010. Offsets: +0 LED (RW, low LED_W bits); +4 switches (RO, SW_W bits zero-extended); +8 free-running 32-bit cycle counter (RO, wraps at 2^32). Offset +C -> error.
  - Anything else -> error.
- Error response: IDLE -> RESP; resp_valid in cycle N+1 with resp_err=1, resp_rdata=0. No RAM/LED side effect.
- Store to RAM: byte-lane write enable from addr[1:0] and size; the write commits at the accept edge. resp_valid at N+1 with rdata 0.
- Store to MMIO +0 updates led_out at the accept edge. Stores to +4/+8 are ignored with no error.
- Load from RAM: IDLE -> WAIT -> RESP; resp_valid in cycle N+1+READ_LAT.
- Load from MMIO: resp_valid at N+1.
- Load extraction: lane selected by addr[1:0]. lb/lh sign-extend; lbu/lhu zero-extend.
- Read-after-write: a load accepted after a store to the same address returns the new data.
- Switches pass through a 2-flop synchronizer before being readable.
- Counter increments every cycle, including during reset release; it is 0 in the first cycle after reset deasserts.
- rst during WAIT/RESP: return to IDLE; the pending response is dropped (no resp_valid); RAM keeps any write already committed.
- Throughput: at most one request per 2 cycles for stores/MMIO, and one per READ_LAT+2 for RAM loads.

Test Plan:
1. sw addr 0x10 data 0xDEADBEEF, then lw 0x10 (READ_LAT=1) -> store resp at N+1 with err=0; load resp_valid 2 cycles after accept, rdata=0xDEADBEEF, stall high for the 2 cycles before resp.
2. After test 1: lb 0x13 -> 0xFFFFFFDE; lbu 0x13 -> 0x000000DE; lh 0x12 -> 0xFFFFDEAD; lhu 0x10 -> 0x0000BEEF.
3. sb 0x11 data 0x000000AA, then lw 0x10 -> 0xDEADAAEF; other lanes unchanged.
4. sw MMIO_BASE data 0x1234 -> led_out=0x1234 the cycle after accept. sw_in=0x00F0 held 3 cycles, lw MMIO_BASE+4 -> 0x000000F0. Two lw MMIO_BASE+8 accepted 5 cycles apart -> values differ by 5.
5. lw 0x2 -> resp_err=1, rdata=0. sh 0x1 -> err, RAM unchanged. lw 4*DEPTH -> err. lw MMIO_BASE+0xC -> err. Every error response arrives at N+1.
6. lw accepted, rst=1 during WAIT -> no resp_valid, req_ready=1 and led_out=0 after reset; then lw of a previously written address returns the stored value.
